// File: rtl/alut_apb_req_if.sv
// rtl/alut_apb_req_if.sv - request/response and APB signal bundle for the ALUT APB requester
interface alut_apb_req_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;

  // slave: the requester block itself (accepts requests, drives the APB bus)
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/alut_apb_req.sv
// rtl/alut_apb_req.sv - buffered APB2 master for the address-lookup-table register port
module alut_apb_req #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int LVL_W      = 3
) (
  input  logic             pclk,
  input  logic             p_reset,
  alut_apb_req_if.slave    bus,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t                  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q, level_d;
  state_e                state_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q, rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic push, pop, rsp_free;
  req_t head;

  assign bus.req_ready = (level_q < LVL_W'(FIFO_DEPTH));
  assign push          = bus.req_valid && bus.req_ready;
  // A pop is only allowed when the completion it will produce has somewhere to land
  assign rsp_free      = !rsp_valid_q || bus.rsp_ready;
  assign pop           = (state_q == IDLE) && (level_q != '0) && rsp_free;
  assign head          = mem_q[rd_ptr_q];
  assign level_d       = level_q + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge pclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
    end
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;

      if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pop) begin
            paddr_q  <= head.addr;
            pwrite_q <= head.write;
            pwdata_q <= head.write ? head.wdata : '0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_write_q <= pwrite_q;
          rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign busy       = (state_q != IDLE) || (level_q != '0);
  assign fifo_level = level_q;
endmodule

// File: tb/tb_alut_apb_req.sv
// tb/tb_alut_apb_req.sv - directed self-checking bench for alut_apb_req
module tb_alut_apb_req;
  localparam int AW = 7, DW = 32, DEPTH = 4, LW = 3;

  logic          pclk = 1'b0;
  logic          p_reset;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          prd_ovr;
  logic [DW-1:0] prd_val;
  logic          seen;
  int            checks = 0;
  int            errors = 0;

  logic          q_w [16];
  logic [AW-1:0] q_a [16];
  logic [DW-1:0] q_d [16];

  alut_apb_req_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  alut_apb_req #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LVL_W(LW)) dut (
    .pclk(pclk), .p_reset(p_reset), .bus(bus), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 pclk = ~pclk;

  // Register file model: read data is a fixed function of the address
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return 32'h5A00_0000 ^ {a, a, a, a, 4'h3};
  endfunction

  assign bus.prdata = prd_ovr ? prd_val : rd_fn(bus.paddr);

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    q_w[i] = w;
    q_a[i] = a;
    q_d[i] = d;
  endtask

  task automatic drive(input int i);
    bus.req_valid = 1'b1;
    bus.req_write = q_w[i];
    bus.req_addr  = q_a[i];
    bus.req_wdata = q_d[i];
  endtask

  // mode 0: rsp_ready=1 with 3-cycle spacing check; 1: rsp_ready=1; 2: rsp_ready toggles
  task automatic process(input int push_start, input int apb_start, input int n, input int mode);
    int push_i = push_start;
    int apb_i = apb_start;
    int rsp_i = 0;
    int last_setup = -1;
    int budget = 0;
    logic held = 1'b0;
    logic [DW-1:0] held_d = '0;
    while (rsp_i < n && budget < 200) begin
      bus.rsp_ready = (mode == 2) ? budget[0] : 1'b1;
      if (push_i < n && bus.req_ready) drive(push_i);
      else bus.req_valid = 1'b0;
      if (bus.psel && !bus.penable) begin
        chk("setup_addr", bus.paddr, q_a[apb_i]);
        chk("setup_write", bus.pwrite, q_w[apb_i]);
        chk("setup_wdata", bus.pwdata, q_w[apb_i] ? q_d[apb_i] : '0);
        if (mode == 0 && last_setup >= 0) chk("setup_gap", budget - last_setup, 3);
        last_setup = budget;
      end
      if (bus.penable) begin
        chk("access_psel", bus.psel, 1'b1);
        chk("access_addr", bus.paddr, q_a[apb_i]);
        apb_i++;
      end
      if (held) chk("rsp_hold", bus.rsp_rdata, held_d);
      held   = bus.rsp_valid && !bus.rsp_ready;
      held_d = bus.rsp_rdata;
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_write", bus.rsp_write, q_w[rsp_i]);
        chk("rsp_rdata", bus.rsp_rdata, q_w[rsp_i] ? '0 : rd_fn(q_a[rsp_i]));
        rsp_i++;
      end
      if (bus.req_valid && bus.req_ready) push_i++;
      tick();
      budget++;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("all_rsp", rsp_i, n);
    chk("all_push", push_i, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    p_reset = 1'b1;
    prd_ovr = 1'b0;
    prd_val = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_paddr", bus.paddr, 0);
    p_reset = 1'b0;
    tick();
    chk("rst_req_ready", bus.req_ready, 1'b1);

    // Single write with cycle-exact latency
    set_req(0, 1'b1, 7'h14, 32'hDEAD_BEEF);
    drive(0);
    tick();
    bus.req_valid = 1'b0;
    chk("w_level_c1", fifo_level, 1);
    chk("w_busy_c1", busy, 1'b1);
    tick();
    chk("w_psel_c2", bus.psel, 1'b1);
    chk("w_penable_c2", bus.penable, 1'b0);
    chk("w_paddr_c2", bus.paddr, 7'h14);
    chk("w_pwrite_c2", bus.pwrite, 1'b1);
    chk("w_pwdata_c2", bus.pwdata, 32'hDEAD_BEEF);
    tick();
    chk("w_penable_c3", bus.penable, 1'b1);
    chk("w_pwdata_c3", bus.pwdata, 32'hDEAD_BEEF);
    tick();
    chk("w_rsp_valid_c4", bus.rsp_valid, 1'b1);
    chk("w_rsp_write_c4", bus.rsp_write, 1'b1);
    chk("w_rsp_rdata_c4", bus.rsp_rdata, 0);
    chk("w_psel_c4", bus.psel, 1'b0);
    chk("w_busy_c4", busy, 1'b0);
    tick();
    chk("w_rsp_hold", bus.rsp_valid, 1'b1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("w_rsp_clear", bus.rsp_valid, 1'b0);

    // Single read with forced prdata; wdata must not leak onto pwdata
    prd_ovr = 1'b1;
    prd_val = 32'h1234_5678;
    set_req(0, 1'b0, 7'h08, 32'hFFFF_FFFF);
    drive(0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("r_paddr_c2", bus.paddr, 7'h08);
    chk("r_pwrite_c2", bus.pwrite, 1'b0);
    chk("r_pwdata_c2", bus.pwdata, 0);
    tick();
    chk("r_pwdata_c3", bus.pwdata, 0);
    tick();
    chk("r_rsp_valid", bus.rsp_valid, 1'b1);
    chk("r_rsp_write", bus.rsp_write, 1'b0);
    chk("r_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    prd_ovr = 1'b0;

    // Fill and backpressure: five pushes with the response slot blocked
    set_req(0, 1'b1, 7'h01, 32'h1111_1111);
    set_req(1, 1'b0, 7'h02, 32'h0);
    set_req(2, 1'b1, 7'h03, 32'h3333_3333);
    set_req(3, 1'b0, 7'h04, 32'h0);
    set_req(4, 1'b1, 7'h05, 32'h5555_5555);
    set_req(5, 1'b1, 7'h06, 32'h6666_6666);
    for (int i = 0; i < 5; i++) begin
      drive(i);
      tick();
      if (i == 0) chk("bp_level_c1", fifo_level, 1);
    end
    chk("bp_level_full", fifo_level, 4);
    chk("bp_req_ready", bus.req_ready, 1'b0);
    chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
    drive(5);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_stall_level", fifo_level, 4);
      chk("bp_stall_psel", bus.psel, 1'b0);
    end
    bus.req_valid = 1'b0;
    process(5, 1, 5, 1);

    // Streaming alternating write/read
    chk("st_idle", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      set_req(i, (i % 2) == 0, 7'(8'h10 + i), 32'h0101_0101 * (i + 1) + 32'h100);
    end
    process(0, 0, 8, 0);

    // Reset while a read is in ACCESS with two entries queued
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 7'h21, '0);
    set_req(1, 1'b0, 7'h22, '0);
    set_req(2, 1'b0, 7'h23, '0);
    for (int i = 0; i < 3; i++) begin
      drive(i);
      tick();
    end
    bus.req_valid = 1'b0;
    chk("rm_penable", bus.penable, 1'b1);
    chk("rm_level", fifo_level, 2);
    p_reset = 1'b1;
    tick();
    p_reset = 1'b0;
    chk("rm_psel", bus.psel, 1'b0);
    chk("rm_penable_after", bus.penable, 1'b0);
    chk("rm_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rm_level_after", fifo_level, 0);
    chk("rm_req_ready", bus.req_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | bus.rsp_valid | bus.psel;
    end
    chk("rm_no_activity", seen, 1'b0);
    bus.rsp_ready = 1'b0;

    // Pointer wrap: 2*DEPTH mixed requests with a toggling consumer
    for (int i = 0; i < 2 * DEPTH; i++) begin
      set_req(i, (i % 3) != 1, 7'(8'h40 + 3 * i), 32'hC0DE_0000 + 32'(i * 17));
    end
    process(0, 0, 2 * DEPTH, 2);
    chk("end_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
